hamming_memory_scrubber: RTL



---
 rtl/hamming_memory_scrubber.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/hamming_memory_scrubber.sv
// Background scrubber: walks every address, checks the Hamming syndrome, writes back single-bit fixes.
// Optional error log outputs are enabled with HAMMING_MEMORY_SCRUBBER_ERROR_LOG_EN.
module hamming_memory_scrubber #(
    parameter int BLOCK_WIDTH    = 15,
    parameter int DEPTH          = 256,
    parameter int INTERVAL       = 1024,
    parameter int COUNT_WIDTH    = 16,
    localparam int ADDRESS_WIDTH  = $clog2(DEPTH),
    localparam int SYNDROME_WIDTH = $clog2(BLOCK_WIDTH + 1)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    output logic                      read_request,
    output logic [ADDRESS_WIDTH-1:0]  read_address,
    input  logic                      read_grant,
    input  logic                      read_data_valid,
    input  logic [BLOCK_WIDTH-1:0]    read_data,
    output logic                      write_request,
    output logic [ADDRESS_WIDTH-1:0]  write_address,
    output logic [BLOCK_WIDTH-1:0]    write_data,
    input  logic                      write_grant,
    output logic                      busy,
    output logic                      pass_done,
    output logic [COUNT_WIDTH-1:0]    corrected_count,
    output logic [COUNT_WIDTH-1:0]    uncorrectable_count
`ifdef HAMMING_MEMORY_SCRUBBER_ERROR_LOG_EN
    ,
    output logic                      last_error_valid,
    output logic [ADDRESS_WIDTH-1:0]  last_error_address,
    output logic [SYNDROME_WIDTH-1:0] last_error_syndrome
`endif
);

    localparam int INTERVAL_WIDTH = $clog2(INTERVAL + 1);
    localparam logic [INTERVAL_WIDTH-1:0] INTERVAL_LOAD = INTERVAL_WIDTH'(INTERVAL - 1);
    localparam logic [ADDRESS_WIDTH-1:0]  LAST_ADDRESS  = ADDRESS_WIDTH'(DEPTH - 1);
    localparam logic [SYNDROME_WIDTH-1:0] MAX_POSITION  = SYNDROME_WIDTH'(BLOCK_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_READ_REQ, S_READ_WAIT, S_CHECK, S_WRITE_REQ, S_NEXT
    } state_t;

    state_t                      r_state;
    logic [ADDRESS_WIDTH-1:0]    r_address;
    logic [INTERVAL_WIDTH-1:0]   r_interval;
    logic [BLOCK_WIDTH-1:0]      r_block;
    logic                        r_read_request;
    logic [ADDRESS_WIDTH-1:0]    r_read_address;
    logic                        r_write_request;
    logic [ADDRESS_WIDTH-1:0]    r_write_address;
    logic [BLOCK_WIDTH-1:0]      r_write_data;
    logic                        r_busy;
    logic                        r_pass_done;
    logic [COUNT_WIDTH-1:0]      r_corrected_count;
    logic [COUNT_WIDTH-1:0]      r_uncorrectable_count;

    logic [SYNDROME_WIDTH-1:0]   w_syndrome;
    logic                        w_correctable;
    logic [BLOCK_WIDTH-1:0]      w_corrected;
    logic                        w_at_last;

    // XOR of the positions of all set bits equals received parity XOR recomputed parity.
    function automatic logic [SYNDROME_WIDTH-1:0] syndrome_of(input logic [BLOCK_WIDTH-1:0] blk);
        logic [SYNDROME_WIDTH-1:0] s;
        s = '0;
        for (int p = 1; p <= BLOCK_WIDTH; p++) begin
            if (blk[p-1]) s = s ^ SYNDROME_WIDTH'(p);
        end
        return s;
    endfunction

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign w_syndrome    = syndrome_of(r_block);
    assign w_correctable = (w_syndrome != '0) && (w_syndrome <= MAX_POSITION);
    assign w_corrected   = r_block ^ (BLOCK_WIDTH'(1) << (w_syndrome - 1'b1));
    assign w_at_last     = (r_address == LAST_ADDRESS);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state               <= S_IDLE;
            r_address             <= '0;
            r_interval            <= '0;
            r_read_request        <= 1'b0;
            r_read_address        <= '0;
            r_write_request       <= 1'b0;
            r_write_address       <= '0;
            r_write_data          <= '0;
            r_busy                <= 1'b0;
            r_pass_done           <= 1'b0;
            r_corrected_count     <= '0;
            r_uncorrectable_count <= '0;
        end else begin
            r_pass_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_state    <= S_WAIT;
                        r_interval <= INTERVAL_LOAD;
                        r_busy     <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (!enable) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_interval == '0) begin
                        r_state        <= S_READ_REQ;
                        r_read_request <= 1'b1;
                        r_read_address <= r_address;
                    end else begin
                        r_interval <= r_interval - 1'b1;
                    end
                end
                S_READ_REQ: begin
                    if (read_grant) begin
                        r_read_request <= 1'b0;
                        r_state        <= S_READ_WAIT;
                    end
                end
                S_READ_WAIT: begin
                    if (read_data_valid) begin
                        r_block <= read_data;
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_correctable) begin
                        r_write_request   <= 1'b1;
                        r_write_address   <= r_address;
                        r_write_data      <= w_corrected;
                        r_corrected_count <= sat_inc(r_corrected_count);
                        r_state           <= S_WRITE_REQ;
                    end else begin
                        if (w_syndrome != '0) r_uncorrectable_count <= sat_inc(r_uncorrectable_count);
                        r_state     <= S_NEXT;
                        r_pass_done <= w_at_last;
                    end
                end
                S_WRITE_REQ: begin
                    if (write_grant) begin
                        r_write_request <= 1'b0;
                        r_state         <= S_NEXT;
                        r_pass_done     <= w_at_last;
                    end
                end
                S_NEXT: begin
                    r_address <= w_at_last ? '0 : r_address + 1'b1;
                    if (enable) begin
                        r_state    <= S_WAIT;
                        r_interval <= INTERVAL_LOAD;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef HAMMING_MEMORY_SCRUBBER_ERROR_LOG_EN
    logic                        r_last_error_valid;
    logic [ADDRESS_WIDTH-1:0]    r_last_error_address;
    logic [SYNDROME_WIDTH-1:0]   r_last_error_syndrome;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_last_error_valid    <= 1'b0;
            r_last_error_address  <= '0;
            r_last_error_syndrome <= '0;
        end else if (r_state == S_CHECK && w_syndrome != '0) begin
            r_last_error_valid    <= 1'b1;
            r_last_error_address  <= r_address;
            r_last_error_syndrome <= w_syndrome;
        end
    end

    assign last_error_valid    = r_last_error_valid;
    assign last_error_address  = r_last_error_address;
    assign last_error_syndrome = r_last_error_syndrome;
`endif

    assign read_request        = r_read_request;
    assign read_address        = r_read_address;
    assign write_request       = r_write_request;
    assign write_address       = r_write_address;
    assign write_data          = r_write_data;
    assign busy                = r_busy;
    assign pass_done           = r_pass_done;
    assign corrected_count     = r_corrected_count;
    assign uncorrectable_count = r_uncorrectable_count;

endmodule
